// File: rtl/wt_cache_pkg.sv
// Shared write-through cache types: RRIP re-reference values, SHiP signatures
// and the replacement unit's state encoding.
package wt_cache_pkg;

  typedef logic [1:0] rrpv_t;

  localparam rrpv_t RRPV_NEAR    = 2'd0;
  localparam rrpv_t RRPV_DISTANT = 2'd3;

  localparam int unsigned SHCT_SIG_WIDTH = 14;

  typedef logic [SHCT_SIG_WIDTH-1:0] shct_sig_t;

  typedef enum logic [1:0] {
    RRIP_IDLE   = 2'd0,
    RRIP_SEARCH = 2'd1,
    RRIP_AGE    = 2'd2
  } rrip_state_e;

endpackage : wt_cache_pkg

// File: rtl/wt_dcache_rrip_vsel.sv
// Combinational RRIP victim selector: lowest-index invalid way and
// lowest-index distant (RRPV==3) way of one set.
module wt_dcache_rrip_vsel
  import wt_cache_pkg::*;
#(
  parameter  int unsigned NumWays = 8,
  localparam int unsigned WayW    = $clog2(NumWays)
) (
  input  logic [NumWays-1:0]   way_valid_i,
  input  rrpv_t [NumWays-1:0]  rrpv_i,
  output logic                 has_invalid_o,
  output logic [WayW-1:0]      inv_way_o,
  output logic                 has_distant_o,
  output logic [WayW-1:0]      dist_way_o
);

  // Scan from the top so the last match written is the lowest index.
  always_comb begin
    has_invalid_o = 1'b0;
    inv_way_o     = '0;
    has_distant_o = 1'b0;
    dist_way_o    = '0;
    for (int i = int'(NumWays) - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        has_invalid_o = 1'b1;
        inv_way_o     = WayW'(i);
      end
      if (rrpv_i[i] == RRPV_DISTANT) begin
        has_distant_o = 1'b1;
        dist_way_o    = WayW'(i);
      end
    end
  end

endmodule : wt_dcache_rrip_vsel

// File: rtl/wt_dcache_rrip_repl.sv
// SHiP/RRIP replacement unit: per-line RRPV, signature and reuse bit, victim
// search with aging, and hit/eviction training events for the SHCT predictor.
module wt_dcache_rrip_repl
  import wt_cache_pkg::*;
#(
  parameter  int unsigned NumSets  = 256,
  parameter  int unsigned NumWays  = 8,
  parameter  int unsigned SigWidth = SHCT_SIG_WIDTH,
  localparam int unsigned SetW     = $clog2(NumSets),
  localparam int unsigned WayW     = $clog2(NumWays)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                hit_valid_i,
  input  logic [SetW-1:0]     hit_set_i,
  input  logic [WayW-1:0]     hit_way_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [SetW-1:0]     req_set_i,
  input  logic [SigWidth-1:0] req_sig_i,
  input  logic [NumWays-1:0]  req_way_valid_i,
  output logic                victim_valid_o,
  output logic [WayW-1:0]     victim_way_o,
  output logic [SigWidth-1:0] pred_shct_o,
  input  logic [1:0]          pred_result_i,
  output logic                pred_hit_o,
  output logic [SigWidth-1:0] pred_hit_shct_o,
  output logic                pred_miss_o,
  output logic [SigWidth-1:0] pred_miss_shct_o,
  output logic                pred_outcome_o
);

  rrip_state_e state_q;
  logic [SetW-1:0]     req_set_q;
  logic [SigWidth-1:0] req_sig_q;
  logic [NumWays-1:0]  req_wv_q;

  rrpv_t [NumSets-1:0][NumWays-1:0]               rrpv_q;
  logic  [NumSets-1:0][NumWays-1:0][SigWidth-1:0] sig_q;
  logic  [NumSets-1:0][NumWays-1:0]               outcome_q;

  rrpv_t [NumWays-1:0] set_rrpv;
  rrpv_t [NumWays-1:0] aged_rrpv;
  logic                has_invalid, has_distant;
  logic [WayW-1:0]     inv_way, dist_way;
  logic                victim_sel;
  logic                evict_sel;
  logic [WayW-1:0]     victim_way;
  logic                out_en;

  always_comb begin
    set_rrpv  = rrpv_q[req_set_q];
    aged_rrpv = '0;
    for (int w = 0; w < int'(NumWays); w++) begin
      aged_rrpv[w] = set_rrpv[w] + 2'd1;
    end
  end

  wt_dcache_rrip_vsel #(
    .NumWays (NumWays)
  ) u_vsel (
    .way_valid_i   (req_wv_q),
    .rrpv_i        (set_rrpv),
    .has_invalid_o (has_invalid),
    .inv_way_o     (inv_way),
    .has_distant_o (has_distant),
    .dist_way_o    (dist_way)
  );

  // Invalid ways take priority over distant ones; only the latter evict.
  always_comb begin
    victim_sel = 1'b0;
    evict_sel  = 1'b0;
    victim_way = '0;
    if (state_q == RRIP_SEARCH) begin
      if (has_invalid) begin
        victim_sel = 1'b1;
        victim_way = inv_way;
      end else if (has_distant) begin
        victim_sel = 1'b1;
        evict_sel  = 1'b1;
        victim_way = dist_way;
      end
    end
  end

  assign out_en = !rst_i && !flush_i;

  assign req_ready_o      = out_en && (state_q == RRIP_IDLE);
  assign victim_valid_o   = out_en && victim_sel;
  assign victim_way_o     = victim_valid_o ? victim_way : '0;
  assign pred_shct_o      = rst_i ? '0 : req_sig_q;
  assign pred_miss_o      = out_en && evict_sel;
  assign pred_miss_shct_o = pred_miss_o ? sig_q[req_set_q][victim_way] : '0;
  assign pred_outcome_o   = pred_miss_o && outcome_q[req_set_q][victim_way];
  assign pred_hit_o       = out_en && hit_valid_i;
  assign pred_hit_shct_o  = pred_hit_o ? sig_q[hit_set_i][hit_way_i] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RRIP_IDLE;
      req_set_q <= '0;
      req_sig_q <= '0;
      req_wv_q  <= '0;
    end else if (flush_i) begin
      state_q <= RRIP_IDLE;
    end else begin
      case (state_q)
        RRIP_IDLE: begin
          if (req_valid_i) begin
            req_set_q <= req_set_i;
            req_sig_q <= req_sig_i;
            req_wv_q  <= req_way_valid_i;
            state_q   <= RRIP_SEARCH;
          end
        end
        RRIP_SEARCH: state_q <= victim_sel ? RRIP_IDLE : RRIP_AGE;
        RRIP_AGE:    state_q <= RRIP_SEARCH;
        default:     state_q <= RRIP_IDLE;
      endcase
    end
  end

  // Later writes win: aging, then hit promotion, then victim install.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rrpv_q    <= {(NumSets*NumWays){RRPV_DISTANT}};
      sig_q     <= '0;
      outcome_q <= '0;
    end else begin
      if (state_q == RRIP_AGE) begin
        rrpv_q[req_set_q] <= aged_rrpv;
      end
      if (hit_valid_i) begin
        rrpv_q[hit_set_i][hit_way_i]    <= RRPV_NEAR;
        outcome_q[hit_set_i][hit_way_i] <= 1'b1;
      end
      if (victim_sel) begin
        rrpv_q[req_set_q][victim_way]    <= rrpv_t'(pred_result_i);
        sig_q[req_set_q][victim_way]     <= req_sig_q;
        outcome_q[req_set_q][victim_way] <= 1'b0;
      end
    end
  end

endmodule : wt_dcache_rrip_repl
